// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad. Columns are driven active-low one at a time and the
// rows are read back. One full pass over the four columns makes a frame. The
// result of each frame is debounced over DEBOUNCE_CNT identical frames before
// the key state changes. A press emits a single key_valid pulse. A release only
// drops key_pressed.
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When this macro is defined, a held key re-issues key_valid after
//   REPEAT_DELAY frames, and then again every REPEAT_RATE frames.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   row[3:0]    in   keypad rows, active-low, asynchronous to clk
//   col[3:0]    out  keypad column drive, active-low one-hot (1111 after reset)
//   key_code    out  last accepted key, row_index*4 + col_index
//   key_valid   out  one-clk pulse when key_code is (re)issued
//   key_pressed out  high while an accepted key is held
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV_W   = 16,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  // Internal key encoding: bit 4 set means "no key", otherwise [3:0] is the code.
  localparam logic [4:0] KEY_NONE   = 5'b10000;
  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_CNT);

  // Returns {found, row_index} for the first low row bit, row 0 first.
  function automatic logic [2:0] first_low(input logic [3:0] r);
    logic [2:0] res;
    if (r[0] == 1'b0) begin
      res = 3'b100;
    end else if (r[1] == 1'b0) begin
      res = 3'b101;
    end else if (r[2] == 1'b0) begin
      res = 3'b110;
    end else if (r[3] == 1'b0) begin
      res = 3'b111;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  logic [3:0]            row_s1_q, row_s2_q;
  logic [SCAN_DIV_W-1:0] div_q, div_d;
  logic [3:0]            col_q, col_d;
  logic [4:0]            acc_q, acc_d;       // partial frame result
  logic [4:0]            cand_q, cand_d;     // debounce candidate
  logic [3:0]            stable_q, stable_d;
  logic [4:0]            state_q, state_d;   // accepted key state
  logic [3:0]            key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_pressed_q, key_pressed_d;

  logic       scan_tick_s;
  logic [1:0] col_idx_s;
  logic [2:0] row_hit_s;
  logic [4:0] base_s;
  logic [4:0] merged_s;
  logic       frame_end_s;
  logic [4:0] frame_res_s;
  logic       accept_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_V = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] RATE_V  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_phase_q, rep_phase_d;  // 0: waiting first delay, 1: repeating
  logic [REP_W-1:0] rep_next_s;
`endif

  // Row synchronizer, prescaler, scan and key state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q      <= 4'b1111;
      row_s2_q      <= 4'b1111;
      div_q         <= '0;
      col_q         <= 4'b1111;
      acc_q         <= KEY_NONE;
      cand_q        <= KEY_NONE;
      stable_q      <= 4'd0;
      state_q       <= KEY_NONE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q     <= '0;
      rep_phase_q   <= 1'b0;
`endif
    end else begin
      row_s1_q      <= row;
      row_s2_q      <= row_s1_q;
      div_q         <= div_d;
      col_q         <= col_d;
      acc_q         <= acc_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q     <= rep_cnt_d;
      rep_phase_q   <= rep_phase_d;
`endif
    end
  end

  // Next-state logic: scan sequencing, frame resolution, debounce, acceptance.
  always_comb begin
    div_d         = div_q + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
    col_d         = col_q;
    acc_d         = acc_q;
    cand_d        = cand_q;
    stable_d      = stable_q;
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    frame_end_s   = 1'b0;
    frame_res_s   = KEY_NONE;
    merged_s      = KEY_NONE;
    scan_tick_s   = &div_q;
    row_hit_s     = first_low(row_s2_q);
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d     = rep_cnt_q;
    rep_phase_d   = rep_phase_q;
    rep_next_s    = rep_cnt_q + {{(REP_W-1){1'b0}}, 1'b1};
`endif

    case (col_q)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase

    // Column 0 starts a new frame; later columns only count if nothing earlier hit.
    base_s = (col_q == 4'b1110) ? KEY_NONE : acc_q;
    if (base_s != KEY_NONE) begin
      merged_s = base_s;
    end else if (row_hit_s[2]) begin
      merged_s = {1'b0, row_hit_s[1:0], col_idx_s};
    end else begin
      merged_s = KEY_NONE;
    end

    if (scan_tick_s) begin
      case (col_q)
        4'b1110: col_d = 4'b1101;
        4'b1101: col_d = 4'b1011;
        4'b1011: col_d = 4'b0111;
        4'b0111: col_d = 4'b1110;
        default: col_d = 4'b1110;
      endcase
      // With col=1111 nothing is driven, so there is nothing to sample.
      if (col_q != 4'b1111) begin
        acc_d = merged_s;
        if (col_q == 4'b0111) begin
          frame_end_s = 1'b1;
          frame_res_s = merged_s;
        end else begin
          frame_end_s = 1'b0;
        end
      end else begin
        acc_d = KEY_NONE;
      end
    end else begin
      col_d = col_q;
    end

    if (frame_end_s) begin
      if (frame_res_s == cand_q) begin
        if (stable_q == STABLE_MAX) begin
          stable_d = stable_q;
        end else begin
          stable_d = stable_q + 4'd1;
        end
      end else begin
        cand_d   = frame_res_s;
        stable_d = 4'd1;
      end
    end else begin
      stable_d = stable_q;
    end

    // Acceptance looks at registered debounce state, so it lands one clk after the frame end.
    accept_s = (stable_q == STABLE_MAX) && (cand_q != state_q);

    if (accept_s) begin
      state_d = cand_q;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
`endif
      if (cand_q == KEY_NONE) begin
        key_pressed_d = 1'b0;
      end else begin
        key_code_d    = cand_q[3:0];
        key_pressed_d = 1'b1;
        key_valid_d   = 1'b1;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    // Repeat frames only count while the accepted key is actually seen in the frame.
    else if (frame_end_s && key_pressed_q && (frame_res_s == state_q)) begin
      if (rep_next_s == (rep_phase_q ? RATE_V : DELAY_V)) begin
        key_valid_d = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_next_s;
      end
    end
`endif
    else begin
      state_d = state_q;
    end
  end

  assign col         = col_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_DIV_W=4, DEBOUNCE_CNT=3, REPEAT_DELAY=4
// and REPEAT_RATE=2. A tick comes every 16 clk, so one frame is 64 clk.
//
// Timing model, with cyc counting posedges since reset release and read at the
// negedge:
//   - frame k ends on posedge index 15+64k.
//   - accepting a key after frame k shows key_valid at cyc 17+64k.
//   - a repeat pulse at frame k shows at cyc 16+64k.
//   - stimulus for frame k is applied at cyc 64k-44, before column 0 is sampled.
//
// Expected pulses {code, cyc} are pushed to a queue when stimulus is applied.
// They are popped when key_valid is seen.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic [15:0] keys;

  int total_cnt;
  int bad_cnt;
  int cyc;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb_q[$];

  logic [3:0] col_pat [4];

  keypad_scanner #(
    .SCAN_DIV_W  (4),
    .DEBOUNCE_CNT(3),
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key pulls its row low while its column is driven.
  always @* begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
      end
    end
  end

  // Cycle counter, aligned with the DUT prescaler.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && key_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_valid_cyc", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check_val("valid_code", 32'(key_code), 32'(e.code));
        check_val("valid_cyc", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic push_exp(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    while (cyc < c) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        $display("FAIL wait_cyc: timeout at cyc %0d waiting for %0d", cyc, c);
        $fatal(1);
      end
    end
  endtask

  // Reset is raised between clock edges and checked before any edge arrives.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_col", 32'(col), 32'(4'b1111));
    check_val("rst_key_code", 32'(key_code), 32'd0);
    check_val("rst_key_valid", 32'(key_valid), 32'd0);
    check_val("rst_key_pressed", 32'(key_pressed), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int t_frame(input int k);
    return 64*k - 44;
  endfunction

  function automatic int t_accept(input int k);
    return 17 + 64*k;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b0;
    keys      = 16'h0000;
    col_pat[0] = 4'b1110;
    col_pat[1] = 4'b1101;
    col_pat[2] = 4'b1011;
    col_pat[3] = 4'b0111;

    // Idle: the column rotation holds, and no output activity occurs.
    apply_reset();
    wait_cyc(8);
    check_val("idle_col_pre_tick", 32'(col), 32'(4'b1111));
    for (int j = 0; j < 80; j++) begin
      wait_cyc(24 + 16*j);
      check_val("idle_col", 32'(col), 32'(col_pat[j%4]));
    end
    check_val("idle_pressed", 32'(key_pressed), 32'd0);
    check_val("idle_code", 32'(key_code), 32'd0);

    // Single key 9: press, then release.
    apply_reset();
    wait_cyc(t_frame(1));
    keys = 16'h0200;
    push_exp(4'd9, t_accept(3));
    wait_cyc(t_accept(3) - 1);
    check_val("k9_pressed_before", 32'(key_pressed), 32'd0);
    wait_cyc(t_accept(3));
    check_val("k9_pressed", 32'(key_pressed), 32'd1);
    check_val("k9_code", 32'(key_code), 32'd9);
    wait_cyc(t_frame(6));
    keys = 16'h0000;
    wait_cyc(t_accept(8) - 1);
    check_val("k9_rel_pressed_before", 32'(key_pressed), 32'd1);
    wait_cyc(t_accept(8));
    check_val("k9_rel_pressed", 32'(key_pressed), 32'd0);
    check_val("k9_rel_code", 32'(key_code), 32'd9);
    wait_cyc(600);
    check_val("k9_sb_empty", 32'(sb_q.size()), 32'd0);

    // A two-frame glitch on key 3 is ignored.
    apply_reset();
    wait_cyc(t_frame(1));
    keys = 16'h0008;
    wait_cyc(t_frame(3));
    keys = 16'h0000;
    wait_cyc(600);
    check_val("glitch_pressed", 32'(key_pressed), 32'd0);
    check_val("glitch_code", 32'(key_code), 32'd0);
    check_val("glitch_sb_empty", 32'(sb_q.size()), 32'd0);

    // Keys 5 and 14 together: 5 wins, then 14 after 5 is released.
    apply_reset();
    wait_cyc(t_frame(1));
    keys = 16'h4020;
    push_exp(4'd5, t_accept(3));
    wait_cyc(t_frame(5));
    keys = 16'h4000;
    push_exp(4'd14, t_accept(7));
    wait_cyc(300);
    check_val("multi_code5", 32'(key_code), 32'd5);
    wait_cyc(t_accept(7) + 5);
    check_val("multi_code14", 32'(key_code), 32'd14);
    check_val("multi_pressed", 32'(key_pressed), 32'd1);
    wait_cyc(500);
    check_val("multi_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while key 9 is accepted and held forces a full fresh debounce.
    apply_reset();
    wait_cyc(t_frame(1));
    keys = 16'h0200;
    push_exp(4'd9, t_accept(3));
    wait_cyc(300);
    check_val("mid_pressed_before_rst", 32'(key_pressed), 32'd1);
    apply_reset();
    push_exp(4'd9, t_accept(3));
    wait_cyc(1);
    check_val("mid_valid_after_rst", 32'(key_valid), 32'd0);
    wait_cyc(t_accept(3) - 1);
    check_val("mid_pressed_pre", 32'(key_pressed), 32'd0);
    check_val("mid_code_pre", 32'(key_code), 32'd0);
    wait_cyc(300);
    check_val("mid_code", 32'(key_code), 32'd9);
    check_val("mid_pressed", 32'(key_pressed), 32'd1);
    check_val("mid_sb_empty", 32'(sb_q.size()), 32'd0);

    // Key 7 is held for 12 frames (auto-repeat when enabled).
    apply_reset();
    wait_cyc(t_frame(1));
    keys = 16'h0080;
    push_exp(4'd7, t_accept(3));
`ifdef KEYPAD_REPEAT_EN
    push_exp(4'd7, 16 + 64*7);
    push_exp(4'd7, 16 + 64*9);
    push_exp(4'd7, 16 + 64*11);
`endif
    wait_cyc(t_frame(13));
    keys = 16'h0000;
    wait_cyc(1000);
    check_val("rep_pressed", 32'(key_pressed), 32'd0);
    check_val("rep_code", 32'(key_code), 32'd7);
    check_val("rep_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
